// File: rtl/up_apb4.sv
// up_apb4: registered APB4 slave to uP register-bank bridge with timeout, access filtering and PSLVERR
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   s_apb_*                  APB4 slave side (paddr, psel, penable, pwrite, pprot, pwdata, pstrb in;
//                            pready, prdata, pslverr out)
//   up_rreq/rack/raddr/rdata uP read channel: level request held until rack, rdata valid with rack
//   up_wreq/wack/waddr/wdata/wstrb  uP write channel: level request held until wack
module up_apb4 #(
   parameter int ADDRESS_WIDTH   = 16,
   parameter int BUS_WIDTH       = 4,
   parameter int TIMEOUT_CYCLES  = 255,
   parameter bit ERR_ON_MISALIGN = 1,
   parameter bit PRIV_ONLY       = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDRESS_WIDTH-1:0] s_apb_paddr,
   input  logic                     s_apb_psel,
   input  logic                     s_apb_penable,
   input  logic                     s_apb_pwrite,
   input  logic [2:0]               s_apb_pprot,
   input  logic [BUS_WIDTH*8-1:0]   s_apb_pwdata,
   input  logic [BUS_WIDTH-1:0]     s_apb_pstrb,
   output logic                     s_apb_pready,
   output logic [BUS_WIDTH*8-1:0]   s_apb_prdata,
   output logic                     s_apb_pslverr,
   output logic                     up_rreq,
   input  logic                     up_rack,
   output logic [ADDRESS_WIDTH-1:0] up_raddr,
   input  logic [BUS_WIDTH*8-1:0]   up_rdata,
   output logic                     up_wreq,
   input  logic                     up_wack,
   output logic [ADDRESS_WIDTH-1:0] up_waddr,
   output logic [BUS_WIDTH*8-1:0]   up_wdata,
   output logic [BUS_WIDTH-1:0]     up_wstrb
);
   localparam int DW = BUS_WIDTH * 8;
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
   logic [1:0]               state;
   logic [CW-1:0]            cnt;
   logic [ADDRESS_WIDTH-1:0] addr;
   logic                     wr;
   logic                     err;
   logic [DW-1:0]            wr_data;
   logic [DW-1:0]            rd_data;
   logic [BUS_WIDTH-1:0]     wr_strb;
   logic                     setup;
   logic                     illegal;
   logic                     ack;
   logic                     to_hit;
   logic                     unused;
   always_comb begin
      setup   = s_apb_psel && !s_apb_penable;
      // low address bits below the bus width must be zero for an aligned transfer
      illegal = (ERR_ON_MISALIGN && ((s_apb_paddr & ADDRESS_WIDTH'(BUS_WIDTH - 1)) != '0)) ||
                (PRIV_ONLY && !s_apb_pprot[0]);
      // only the ack matching the pending direction counts
      ack     = wr ? up_wack : up_rack;
      to_hit  = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
   end
   assign unused = ^s_apb_pprot[2:1];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         addr    <= '0;
         wr      <= 1'b0;
         err     <= 1'b0;
         wr_data <= '0;
         wr_strb <= '0;
         rd_data <= '0;
      end else begin
         case (state)
            IDLE: if (setup) begin
               addr    <= s_apb_paddr;
               wr      <= s_apb_pwrite;
               wr_data <= s_apb_pwdata;
               wr_strb <= s_apb_pwrite ? s_apb_pstrb : '0;
               cnt     <= '0;
               if (illegal) begin
                  state   <= RESP;
                  err     <= 1'b1;
                  rd_data <= '0;
               end else begin
                  state <= WAIT;
                  err   <= 1'b0;
               end
            end
            WAIT: begin
               cnt <= cnt + CW'(1);
               // ack takes priority over a timeout landing in the same cycle
               if (ack) begin
                  state   <= RESP;
                  err     <= 1'b0;
                  rd_data <= wr ? '0 : up_rdata;
               end else if (to_hit) begin
                  state   <= RESP;
                  err     <= 1'b1;
                  rd_data <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   // requests decode straight from the state flop so reset drops them asynchronously
   assign s_apb_pready  = state == RESP;
   assign s_apb_pslverr = (state == RESP) && err;
   assign s_apb_prdata  = rd_data;
   assign up_rreq       = (state == WAIT) && !wr;
   assign up_wreq       = (state == WAIT) && wr;
   assign up_raddr      = addr;
   assign up_waddr      = addr;
   assign up_wdata      = wr_data;
   assign up_wstrb      = wr_strb;
endmodule

// File: tb/tb_up_apb4.sv
// tb_up_apb4: directed table-driven bench for up_apb4 (timeout 8, privileged-only, misalign rejection)
module tb_up_apb4;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] paddr = '0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [2:0]  pprot = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic        pready, pslverr;
   logic [31:0] prdata;
   logic        rreq, rack = 1'b0, wreq, wack = 1'b0;
   logic [15:0] raddr, waddr;
   logic [31:0] rdata = '0, wdata;
   logic [3:0]  wstrb;
   always #5 clk = ~clk;
   up_apb4 #(
      .ADDRESS_WIDTH(16), .BUS_WIDTH(4), .TIMEOUT_CYCLES(8), .ERR_ON_MISALIGN(1), .PRIV_ONLY(1)
   ) dut (
      .clk(clk), .rst(rst),
      .s_apb_paddr(paddr), .s_apb_psel(psel), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
      .s_apb_pprot(pprot), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb),
      .s_apb_pready(pready), .s_apb_prdata(prdata), .s_apb_pslverr(pslverr),
      .up_rreq(rreq), .up_rack(rack), .up_raddr(raddr), .up_rdata(rdata),
      .up_wreq(wreq), .up_wack(wack), .up_waddr(waddr), .up_wdata(wdata), .up_wstrb(wstrb)
   );
   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [2:0]  prot;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          delay;
      int          wrong_at;
      logic [31:0] rdata;
      int          exp_req;
      bit          exp_err;
      logic [31:0] exp_prdata;
      bit          idle_after;
   } vec_t;
   vec_t vecs[12];
   int n_chk = 0, n_fail = 0;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask
   task automatic check_quiet(input string tag);
      check({tag, " pready"}, pready, 0);
      check({tag, " pslverr"}, pslverr, 0);
      check({tag, " rreq"}, rreq, 0);
      check({tag, " wreq"}, wreq, 0);
   endtask
   task automatic check_all_zero(input string tag);
      check_quiet(tag);
      check({tag, " prdata"}, prdata, 0);
      check({tag, " raddr"}, raddr, 0);
      check({tag, " waddr"}, waddr, 0);
      check({tag, " wdata"}, wdata, 0);
      check({tag, " wstrb"}, wstrb, 0);
   endtask
   task automatic run_vec(input int idx, input vec_t v);
      int  reqs = 0;
      bit  done = 0;
      string t = $sformatf("v%0d", idx);
      @(posedge clk); #1;
      psel = 1; penable = 0; pwrite = v.wr; paddr = v.addr; pprot = v.prot; pwdata = v.wdata; pstrb = v.strb;
      for (int c = 0; c < 20 && !done; c++) begin
         @(posedge clk); #1;
         penable = 1;
         rack  = !v.wr && c == v.delay;
         wack  = v.wr && c == v.delay;
         if (c == v.wrong_at) begin
            if (v.wr) rack = 1; else wack = 1;
         end
         rdata = (c == v.delay) ? v.rdata : 32'hFFFF0000;
         @(negedge clk);
         if (pready) begin
            done = 1;
            check({t, " req_cycles"}, reqs, v.exp_req);
            check({t, " pslverr"}, pslverr, v.exp_err);
            check({t, " prdata"}, prdata, v.exp_prdata);
            check({t, " req_in_resp"}, rreq | wreq, 0);
         end else begin
            reqs++;
            check({t, " rreq"}, rreq, !v.wr);
            check({t, " wreq"}, wreq, v.wr);
            check({t, " raddr"}, raddr, v.addr);
            check({t, " waddr"}, waddr, v.addr);
            check({t, " wdata"}, wdata, v.wdata);
            check({t, " wstrb"}, wstrb, v.wr ? v.strb : 4'h0);
         end
      end
      if (!done) check({t, " pready_budget"}, 0, 1);
      rack = 0; wack = 0;
      if (v.idle_after) begin
         @(posedge clk); #1;
         psel = 0; penable = 0;
         @(negedge clk);
         check_quiet({t, " idle"});
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      //         wr addr      prot    wdata         strb    dly wrong rdata         req err prdata        idle
      vecs[0]  = '{1, 16'h0010, 3'b001, 32'hDEADBEEF, 4'b0101, 2, -1, 32'h0,        3, 0, 32'h0,        1};
      vecs[1]  = '{0, 16'h0004, 3'b001, 32'h0,        4'b0000, 0, -1, 32'h12345678, 1, 0, 32'h12345678, 1};
      vecs[2]  = '{0, 16'h0002, 3'b001, 32'h0,        4'b0000, 0, -1, 32'h0,        0, 1, 32'h0,        1};
      vecs[3]  = '{0, 16'h0008, 3'b001, 32'h0,        4'b0000, 1, -1, 32'hAAAA5555, 2, 0, 32'hAAAA5555, 1};
      vecs[4]  = '{1, 16'h0020, 3'b000, 32'h11223344, 4'b1111, 0, -1, 32'h0,        0, 1, 32'h0,        1};
      vecs[5]  = '{0, 16'h000C, 3'b011, 32'h0,        4'b0000, 3,  1, 32'h0BADF00D, 4, 0, 32'h0BADF00D, 1};
      vecs[6]  = '{0, 16'h0030, 3'b001, 32'h0,        4'b0000, -1, -1, 32'h0,       8, 1, 32'h0,        1};
      vecs[7]  = '{1, 16'h0040, 3'b101, 32'h01020304, 4'b1111, 0, -1, 32'h0,        1, 0, 32'h0,        0};
      vecs[8]  = '{0, 16'h0044, 3'b001, 32'h0,        4'b0000, 1, -1, 32'hCAFEBABE, 2, 0, 32'hCAFEBABE, 0};
      vecs[9]  = '{1, 16'h0041, 3'b001, 32'h0,        4'b0001, 0, -1, 32'h0,        0, 1, 32'h0,        1};
      vecs[10] = '{0, 16'h0050, 3'b001, 32'h0,        4'b0000, 0, -1, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0};
      vecs[11] = '{1, 16'h0054, 3'b001, 32'hA5A5A5A5, 4'b1000, 0, -1, 32'h0,        1, 0, 32'h0,        1};
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      check_all_zero("post_reset");
      // access phase without a preceding setup phase must be ignored
      @(posedge clk); #1;
      psel = 1; penable = 1; paddr = 16'h0010; pprot = 3'b001;
      repeat (2) begin
         @(negedge clk);
         check_quiet("enable_only");
         @(posedge clk); #1;
      end
      psel = 0; penable = 0;
      for (int i = 0; i < 12; i++) begin
         run_vec(i, vecs[i]);
         if (i == 6) begin
            // late rack after a timeout must not restart or capture anything
            @(posedge clk); #1;
            rack = 1; rdata = 32'h5555AAAA;
            @(negedge clk);
            check_quiet("late_rack");
            @(posedge clk); #1;
            rack = 0;
            @(negedge clk);
            check_quiet("after_late_rack");
            check("late_rack prdata", prdata, 0);
         end
      end
      // read with a wrong-type ack, then reset while waiting
      @(posedge clk); #1;
      psel = 1; penable = 0; pwrite = 0; paddr = 16'h0060; pprot = 3'b001;
      @(posedge clk); #1;
      penable = 1; wack = 1;
      @(negedge clk);
      check("rst_seq rreq w/ wack", rreq, 1);
      @(posedge clk); #1;
      wack = 0;
      @(negedge clk);
      check("rst_seq rreq held", rreq, 1);
      check("rst_seq raddr", raddr, 16'h0060);
      @(posedge clk); #1;
      rst = 1;
      #1;
      check_all_zero("async_reset");
      psel = 0; penable = 0;
      @(negedge clk);
      check_all_zero("reset_hold");
      @(posedge clk); #1;
      rst = 0;
      run_vec(12, vecs[1]);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
